alu_seq: RTL and testbench

Parametrised, registered accumulator ALU with a start/busy/done handshake. Single-cycle arithmetic and logic operations complete in one clock. Shift and multiply operations run iteratively over several cycles. The block sits between the accumulator/register file and the control FSM. It provides a registered result and a full Z/N/C/V flag set for branch decisions.

---
 rtl/alu_seq_if.sv | 27 ++
 rtl/alu_seq.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle between the control FSM (master)
// and the sequential accumulator ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] ac;
  logic [WIDTH-1:0] r;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;

  modport master (
    output start, op, ac, r,
    input  busy, done, result, flag_z, flag_n, flag_c, flag_v
  );

  modport slave (
    input  start, op, ac, r,
    output busy, done, result, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered accumulator ALU with start/busy/done handshake.
// Arithmetic/logic ops finish on the accepting edge; shifts run one bit per
// edge and MUL runs one multiplier bit per edge (LSB first, shift-add).
// The accepting edge already performs the first shift/multiply step, so an
// operation of k steps completes k edges after it was accepted.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic      clk,
  input  logic      reset,
  alu_seq_if.slave  bus
);

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_CLR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_ADC  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_ASR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2
  } state_t;

  // One shift step: returns {bit shifted out, shifted value}.
  function automatic logic [WIDTH:0] shift_step(input logic [3:0] sop,
                                                input logic [WIDTH-1:0] v);
    logic [WIDTH:0] o;
    case (sop)
      OP_SHL:  o = {v, 1'b0};
      OP_SHR:  o = {v[0], 1'b0, v[WIDTH-1:1]};
      OP_ASR:  o = {v[0], v[WIDTH-1], v[WIDTH-1:1]};
      default: o = {1'b0, v};
    endcase
    return o;
  endfunction

  // One shift-add step: p = {partial high, remaining multiplier bits}.
  // The add carry is kept by shifting the (WIDTH+1)-bit sum back into p.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] p,
                                                  input logic [WIDTH-1:0]   mc);
    logic [WIDTH:0] sum;
    if (p[0]) begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mc};
    end else begin
      sum = {1'b0, p[2*WIDTH-1:WIDTH]};
    end
    return {sum, p[WIDTH-1:1]};
  endfunction

  // Signed overflow of a + b (+cin) producing s.
  function automatic logic add_ovf(input logic a, input logic b, input logic s);
    return (a == b) && (s != a);
  endfunction

  // Signed overflow of a - b producing s.
  function automatic logic sub_ovf(input logic a, input logic b, input logic s);
    return (a != b) && (s != a);
  endfunction

  state_t                 state_r;
  logic [3:0]             op_r;
  logic [SHW-1:0]         cnt_r;
  logic [2*WIDTH-1:0]     acc_r;
  logic [WIDTH-1:0]       mcand_r;
  logic [WIDTH-1:0]       result_r;
  logic                   flag_z_r;
  logic                   flag_n_r;
  logic                   flag_c_r;
  logic                   flag_v_r;
  logic                   busy_r;
  logic                   done_r;

  logic [WIDTH:0]         wide_s;
  logic [WIDTH-1:0]       res_s;
  logic                   c_s;
  logic                   v_s;
  logic [SHW-1:0]         amt_s;
  logic [SHW-1:0]         k_s;
  logic [3:0]             sh_op_s;
  logic [WIDTH-1:0]       sh_src_s;
  logic [WIDTH:0]         sh_out_s;
  logic [WIDTH-1:0]       sh_val_s;
  logic                   sh_c_s;
  logic [2*WIDTH-1:0]     mul_src_s;
  logic [WIDTH-1:0]       mul_mc_s;
  logic [2*WIDTH-1:0]     mul_next_s;

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;
  assign bus.flag_z = flag_z_r;
  assign bus.flag_n = flag_n_r;
  assign bus.flag_c = flag_c_r;
  assign bus.flag_v = flag_v_r;

  // Single-cycle result, carry and overflow for the incoming request.
  always_comb begin
    wide_s = {(WIDTH+1){1'b0}};
    res_s  = bus.ac;
    c_s    = 1'b0;
    v_s    = 1'b0;
    case (bus.op)
      OP_ADD: begin
        wide_s = {1'b0, bus.ac} + {1'b0, bus.r};
        res_s  = wide_s[WIDTH-1:0];
        c_s    = wide_s[WIDTH];
        v_s    = add_ovf(bus.ac[WIDTH-1], bus.r[WIDTH-1], wide_s[WIDTH-1]);
      end
      OP_SUB: begin
        wide_s = {1'b0, bus.ac} - {1'b0, bus.r};
        res_s  = wide_s[WIDTH-1:0];
        c_s    = wide_s[WIDTH];
        v_s    = sub_ovf(bus.ac[WIDTH-1], bus.r[WIDTH-1], wide_s[WIDTH-1]);
      end
      OP_INC: begin
        wide_s = {1'b0, bus.ac} + (WIDTH+1)'(1);
        res_s  = wide_s[WIDTH-1:0];
        c_s    = wide_s[WIDTH];
        v_s    = add_ovf(bus.ac[WIDTH-1], 1'b0, wide_s[WIDTH-1]);
      end
      OP_ADC: begin
        wide_s = {1'b0, bus.ac} + {1'b0, bus.r} + {{WIDTH{1'b0}}, flag_c_r};
        res_s  = wide_s[WIDTH-1:0];
        c_s    = wide_s[WIDTH];
        v_s    = add_ovf(bus.ac[WIDTH-1], bus.r[WIDTH-1], wide_s[WIDTH-1]);
      end
      OP_CLR:  res_s = {WIDTH{1'b0}};
      OP_AND:  res_s = bus.ac & bus.r;
      OP_OR:   res_s = bus.ac | bus.r;
      OP_XOR:  res_s = bus.ac ^ bus.r;
      OP_NOT:  res_s = ~bus.ac;
      OP_PASS: res_s = bus.ac;
      default: res_s = bus.ac;
    endcase
  end

  // Shift amount (capped at WIDTH) and next shift / multiply step.
  always_comb begin
    amt_s = bus.r[SHW-1:0];
    if (amt_s > SHW'(WIDTH)) begin
      k_s = SHW'(WIDTH);
    end else begin
      k_s = amt_s;
    end
    if (state_r == ST_IDLE) begin
      sh_op_s   = bus.op;
      sh_src_s  = bus.ac;
      mul_src_s = {{WIDTH{1'b0}}, bus.r};
      mul_mc_s  = bus.ac;
    end else begin
      sh_op_s   = op_r;
      sh_src_s  = acc_r[WIDTH-1:0];
      mul_src_s = acc_r;
      mul_mc_s  = mcand_r;
    end
    sh_out_s   = shift_step(sh_op_s, sh_src_s);
    sh_val_s   = sh_out_s[WIDTH-1:0];
    sh_c_s     = sh_out_s[WIDTH];
    mul_next_s = mul_step(mul_src_s, mul_mc_s);
  end

  // Control FSM with registered result, flags and handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_PASS;
      cnt_r    <= {SHW{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      mcand_r  <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      flag_z_r <= 1'b0;
      flag_n_r <= 1'b0;
      flag_c_r <= 1'b0;
      flag_v_r <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              OP_SHL, OP_SHR, OP_ASR: begin
                if (k_s == {SHW{1'b0}}) begin
                  result_r <= bus.ac;
                  flag_z_r <= (bus.ac == {WIDTH{1'b0}});
                  flag_n_r <= bus.ac[WIDTH-1];
                  flag_c_r <= 1'b0;
                  flag_v_r <= 1'b0;
                  done_r   <= 1'b1;
                end else if (k_s == SHW'(1)) begin
                  result_r <= sh_val_s;
                  flag_z_r <= (sh_val_s == {WIDTH{1'b0}});
                  flag_n_r <= sh_val_s[WIDTH-1];
                  flag_c_r <= sh_c_s;
                  flag_v_r <= 1'b0;
                  done_r   <= 1'b1;
                end else begin
                  acc_r   <= {{WIDTH{1'b0}}, sh_val_s};
                  op_r    <= bus.op;
                  cnt_r   <= k_s - SHW'(1);
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  state_r <= ST_SHIFT;
                end
              end
              OP_MUL: begin
                acc_r   <= mul_next_s;
                mcand_r <= bus.ac;
                op_r    <= bus.op;
                cnt_r   <= SHW'(WIDTH - 1);
                busy_r  <= 1'b1;
                done_r  <= 1'b0;
                state_r <= ST_MUL;
              end
              default: begin
                result_r <= res_s;
                flag_z_r <= (res_s == {WIDTH{1'b0}});
                flag_n_r <= res_s[WIDTH-1];
                flag_c_r <= c_s;
                flag_v_r <= v_s;
                done_r   <= 1'b1;
              end
            endcase
          end else begin
            done_r <= 1'b0;
          end
        end
        ST_SHIFT: begin
          acc_r <= {{WIDTH{1'b0}}, sh_val_s};
          cnt_r <= cnt_r - SHW'(1);
          if (cnt_r == SHW'(1)) begin
            result_r <= sh_val_s;
            flag_z_r <= (sh_val_s == {WIDTH{1'b0}});
            flag_n_r <= sh_val_s[WIDTH-1];
            flag_c_r <= sh_c_s;
            flag_v_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_IDLE;
          end else begin
            done_r <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_r <= mul_next_s;
          cnt_r <= cnt_r - SHW'(1);
          if (cnt_r == SHW'(1)) begin
            result_r <= mul_next_s[WIDTH-1:0];
            flag_z_r <= (mul_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
            flag_n_r <= mul_next_s[WIDTH-1];
            flag_c_r <= (mul_next_s[2*WIDTH-1:WIDTH] != {WIDTH{1'b0}});
            flag_v_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            state_r  <= ST_IDLE;
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, self-checking bench for alu_seq at WIDTH=8.
// Expected values below are hand-computed; flags are packed {Z,N,C,V}.
module tb_alu_seq;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_INC  = 4'd3;
  localparam logic [3:0] OP_CLR  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_ADC  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_ASR  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_R15  = 4'd15;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] flags();
    return {4'd0, bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
  endfunction

  function automatic logic [7:0] hs();
    return {6'd0, bus.busy, bus.done};
  endfunction

  // Present a request for one edge, then scramble the operand inputs.
  task automatic issue(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.ac    = a;
    bus.r     = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = OP_CLR;
    bus.ac    = 8'h5A;
    bus.r     = 8'hA5;
  endtask

  // Completion cycle: result, flags, done=1, busy=0.
  task automatic expect_done(input string tag, input logic [7:0] res, input logic [3:0] flg);
    chk({tag, "/result"}, bus.result, res);
    chk({tag, "/flags"}, flags(), {4'd0, flg});
    chk({tag, "/busy_done"}, hs(), 8'h01);
  endtask

  task automatic single(input string tag, input logic [3:0] o, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] res, input logic [3:0] flg);
    issue(o, a, b);
    expect_done(tag, res, flg);
  endtask

  // Multi-cycle op of k edges; optionally fires an ignored CLR while busy.
  task automatic multi(input string tag, input logic [3:0] o, input logic [7:0] a,
                       input logic [7:0] b, input int k, input logic [7:0] prev,
                       input logic [7:0] res, input logic [3:0] flg, input bit inject);
    issue(o, a, b);
    for (int j = 1; j < k; j++) begin
      chk({tag, "/busy_phase"}, hs(), 8'h02);
      chk({tag, "/hold_result"}, bus.result, prev);
      if (inject && j == 2) begin
        bus.start = 1'b1;
        bus.op    = OP_CLR;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    expect_done(tag, res, flg);
  endtask

  task automatic idle_cycle(input string tag, input logic [7:0] res);
    @(posedge clk);
    #1;
    chk({tag, "/idle_hs"}, hs(), 8'h00);
    chk({tag, "/idle_result"}, bus.result, res);
  endtask

  initial begin
    tests     = 0;
    fails     = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_PASS;
    bus.ac    = 8'h00;
    bus.r     = 8'h00;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset/result", bus.result, 8'h00);
    chk("reset/flags", flags(), 8'h00);
    chk("reset/busy_done", hs(), 8'h00);
    reset = 1'b0;

    single("add_ovf", OP_ADD, 8'h7F, 8'h01, 8'h80, 4'b0101);
    idle_cycle("add_ovf", 8'h80);
    single("sub_zero", OP_SUB, 8'h05, 8'h05, 8'h00, 4'b1000);
    single("sub_borrow", OP_SUB, 8'h03, 8'h05, 8'hFE, 4'b0110);
    single("add_carry", OP_ADD, 8'hFF, 8'h01, 8'h00, 4'b1010);
    single("adc", OP_ADC, 8'hFF, 8'h00, 8'h00, 4'b1010);
    single("inc_ovf", OP_INC, 8'h7F, 8'h00, 8'h80, 4'b0101);
    single("inc_wrap", OP_INC, 8'hFF, 8'h33, 8'h00, 4'b1010);
    single("and", OP_AND, 8'hF0, 8'h3C, 8'h30, 4'b0000);
    single("or", OP_OR, 8'hF0, 8'h3C, 8'hFC, 4'b0100);
    single("xor", OP_XOR, 8'hF0, 8'h3C, 8'hCC, 4'b0100);
    single("not", OP_NOT, 8'h0F, 8'h00, 8'hF0, 4'b0100);
    single("clr", OP_CLR, 8'h77, 8'h11, 8'h00, 4'b1000);
    single("reserved15", OP_R15, 8'h80, 8'h01, 8'h80, 4'b0100);
    single("pass", OP_PASS, 8'h01, 8'hFF, 8'h01, 4'b0000);
    single("shr_k0", OP_SHR, 8'h5A, 8'h10, 8'h5A, 4'b0000);
    single("shr_k1", OP_SHR, 8'h03, 8'h01, 8'h01, 4'b0010);
    idle_cycle("shr_k1", 8'h01);

    multi("shl3", OP_SHL, 8'h81, 8'h03, 3, 8'h01, 8'h08, 4'b0000, 1'b0);
    multi("asr_cap", OP_ASR, 8'h80, 8'h09, 8, 8'h08, 8'hFF, 4'b0110, 1'b0);
    multi("mul", OP_MUL, 8'h10, 8'h11, 8, 8'hFF, 8'h10, 4'b0010, 1'b1);
    idle_cycle("mul_no_queue", 8'h10);

    issue(OP_MUL, 8'h0F, 8'h0F);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("abort/busy_before", hs(), 8'h02);
    reset = 1'b1;
    #1;
    chk("abort/result", bus.result, 8'h00);
    chk("abort/flags", flags(), 8'h00);
    chk("abort/busy_done", hs(), 8'h00);
    @(posedge clk);
    #1;
    reset = 1'b0;
    single("post_reset_add", OP_ADD, 8'h02, 8'h03, 8'h05, 4'b0000);
    idle_cycle("post_reset_add", 8'h05);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
